// File: rtl/datapath_pipe_pkg.sv
// Shared definitions for datapath_pipe: ALU function codes and the sequencer state.
package datapath_pipe_pkg;

   localparam int unsigned FS_W = 4;

   localparam logic [FS_W-1:0] FS_PASS_A = 4'b0000;
   localparam logic [FS_W-1:0] FS_INC_A  = 4'b0001;
   localparam logic [FS_W-1:0] FS_ADD    = 4'b0010;
   localparam logic [FS_W-1:0] FS_SUB    = 4'b0101;
   localparam logic [FS_W-1:0] FS_DEC_A  = 4'b0110;
   localparam logic [FS_W-1:0] FS_AND    = 4'b1000;
   localparam logic [FS_W-1:0] FS_OR     = 4'b1001;
   localparam logic [FS_W-1:0] FS_XOR    = 4'b1010;
   localparam logic [FS_W-1:0] FS_NOT_A  = 4'b1011;
   localparam logic [FS_W-1:0] FS_PASS_B = 4'b1100;
   localparam logic [FS_W-1:0] FS_SHR_B  = 4'b1101;
   localparam logic [FS_W-1:0] FS_SHL_B  = 4'b1110;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/datapath_pipe_regfile.sv
// 2**RAW x WIDTH register file: two combinational read ports, one synchronous write port.
module regfile_param #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned RAW   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [RAW-1:0]   waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [RAW-1:0]   raddr_a,
   input  logic [RAW-1:0]   raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b
);

   localparam int unsigned DEPTH = 2 ** RAW;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/datapath_pipe.sv
// Single-issue datapath: ALU ops write back in one cycle, loads stall in MEM_WAIT for mem_ack.
// Legal only for WIDTH >= 2*RAW and WIDTH >= AW.
module datapath_pipe
   import datapath_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned RAW   = 4,
   parameter int unsigned AW    = 6
) (
   input  logic             clk_main,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             MB,
   input  logic             MM,
   input  logic             MD,
   input  logic             RW,
   input  logic [RAW-1:0]   DR,
   input  logic [RAW-1:0]   SA,
   input  logic [RAW-1:0]   SB,
   input  logic [FS_W-1:0]  FS,
   input  logic [AW-1:0]    PC,
   input  logic [WIDTH-1:0] DataIn,
   output logic             mem_req,
   input  logic             mem_ack,
   output logic [AW-1:0]    AddrOut,
   output logic [WIDTH-1:0] DataOut,
   output logic             Z,
   output logic             wb_valid
);

   state_t state, state_nxt;

   logic [WIDTH-1:0] rf_a, rf_b, a_op, b_reg, b_op, alu_res, wb_data;
   logic             wr_pend, ld_rw;
   logic [RAW-1:0]   wr_dr, ld_dr;
   logic             accept, mem_done, alu_ld, mem_start, wb_ld;

   regfile_param #(.WIDTH(WIDTH), .RAW(RAW)) u_rf (
      .clk     (clk_main),
      .reset   (reset),
      .we      (wr_pend),
      .waddr   (wr_dr),
      .wdata   (DataOut),
      .raddr_a (SA),
      .raddr_b (SB),
      .rdata_a (rf_a),
      .rdata_b (rf_b)
   );

   // The write-back register is the newest copy of wr_dr until its regfile write lands.
   assign a_op  = (wr_pend && (wr_dr == SA)) ? DataOut : rf_a;
   assign b_reg = (wr_pend && (wr_dr == SB)) ? DataOut : rf_b;
   assign b_op  = MB ? WIDTH'({SA, SB}) : b_reg;

   always_comb begin
      alu_res = '0;
      case (FS)
         FS_PASS_A: alu_res = a_op;
         FS_INC_A:  alu_res = a_op + WIDTH'(1);
         FS_ADD:    alu_res = a_op + b_op;
         FS_SUB:    alu_res = a_op - b_op;
         FS_DEC_A:  alu_res = a_op - WIDTH'(1);
         FS_AND:    alu_res = a_op & b_op;
         FS_OR:     alu_res = a_op | b_op;
         FS_XOR:    alu_res = a_op ^ b_op;
         FS_NOT_A:  alu_res = ~a_op;
         FS_PASS_B: alu_res = b_op;
         FS_SHR_B:  alu_res = b_op >> 1;
         FS_SHL_B:  alu_res = b_op << 1;
         default:   alu_res = '0;
      endcase
   end

   always_ff @(posedge clk_main) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      mem_done  = 1'b0;
      case (state)
         RUN: begin
            accept = in_valid;
            if (in_valid && MD) state_nxt = MEM_WAIT;
         end
         MEM_WAIT: begin
            mem_done = mem_req && mem_ack;
            if (mem_done) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   assign in_ready  = (state == RUN);
   assign alu_ld    = accept && !MD;
   assign mem_start = accept && MD;
   assign wb_ld     = alu_ld || mem_done;
   assign wb_data   = mem_done ? DataIn : alu_res;

   always_ff @(posedge clk_main) begin
      if (reset) begin
         DataOut  <= '0;
         Z        <= 1'b0;
         wb_valid <= 1'b0;
         AddrOut  <= '0;
         mem_req  <= 1'b0;
         wr_pend  <= 1'b0;
         wr_dr    <= '0;
         ld_rw    <= 1'b0;
         ld_dr    <= '0;
      end else begin
         wb_valid <= wb_ld;
         wr_pend  <= 1'b0;
         if (wb_ld) begin
            DataOut <= wb_data;
            Z       <= (wb_data == '0);
            wr_pend <= mem_done ? ld_rw : RW;
            wr_dr   <= mem_done ? ld_dr : DR;
         end
         if (mem_start) begin
            AddrOut <= MM ? PC : a_op[AW-1:0];
            ld_rw   <= RW;
            ld_dr   <= DR;
            mem_req <= 1'b1;
         end else if (mem_done) begin
            mem_req <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_datapath_pipe.sv
// Self-checking bench for datapath_pipe: directed scenarios plus random ops against an architectural model.
module tb_datapath_pipe;

   logic        clk_main = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        MB, MM, MD, RW;
   logic [3:0]  DR, SA, SB, FS;
   logic [5:0]  PC;
   logic [15:0] DataIn;
   logic        mem_req;
   logic        mem_ack;
   logic [5:0]  AddrOut;
   logic [15:0] DataOut;
   logic        Z;
   logic        wb_valid;

   int n_cmp = 0;
   int n_err = 0;

   // Architectural model: registers updated immediately, as if ops ran one at a time.
   logic [15:0] regs [16];
   logic [15:0] last_do;
   logic        last_z;
   logic [5:0]  last_addr;

   datapath_pipe dut (
      .clk_main (clk_main),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .MB       (MB),
      .MM       (MM),
      .MD       (MD),
      .RW       (RW),
      .DR       (DR),
      .SA       (SA),
      .SB       (SB),
      .FS       (FS),
      .PC       (PC),
      .DataIn   (DataIn),
      .mem_req  (mem_req),
      .mem_ack  (mem_ack),
      .AddrOut  (AddrOut),
      .DataOut  (DataOut),
      .Z        (Z),
      .wb_valid (wb_valid)
   );

   always #5 clk_main = ~clk_main;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_alu(input logic [3:0] fs, input logic [15:0] a,
                                           input logic [15:0] b);
      case (fs)
         4'd0:    return a;
         4'd1:    return a + 16'd1;
         4'd2:    return a + b;
         4'd5:    return a - b;
         4'd6:    return a - 16'd1;
         4'd8:    return a & b;
         4'd9:    return a | b;
         4'd10:   return a ^ b;
         4'd11:   return ~a;
         4'd12:   return b;
         4'd13:   return b >> 1;
         4'd14:   return b << 1;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
      last_do   = 16'h0000;
      last_z    = 1'b0;
      last_addr = 6'h00;
   endfunction

   task automatic tick();
      @(posedge clk_main);
      #1;
   endtask

   // Reset for one edge with an op presented, which must be ignored.
   task automatic do_reset(input string tag);
      reset    = 1'b1;
      in_valid = 1'b1;
      MD = 1'b0; MB = 1'b1; FS = 4'b1100; SA = 4'h3; SB = 4'h3; DR = 4'h1; RW = 1'b1;
      mem_ack  = 1'b0;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      model_clear();
      check({tag, "_dataout"}, DataOut, 16'h0000);
      check({tag, "_z"}, Z, 1'b0);
      check({tag, "_wb_valid"}, wb_valid, 1'b0);
      check({tag, "_mem_req"}, mem_req, 1'b0);
      check({tag, "_addrout"}, AddrOut, 6'h00);
      check({tag, "_in_ready"}, in_ready, 1'b1);
   endtask

   task automatic issue_alu(input logic [3:0] fs, input logic mb, input logic [3:0] sa,
                            input logic [3:0] sb, input logic [3:0] dr, input logic rw,
                            input string tag);
      logic [15:0] a, b, exp;
      a   = regs[sa];
      b   = mb ? {8'h00, sa, sb} : regs[sb];
      exp = ref_alu(fs, a, b);
      in_valid = 1'b1;
      MD = 1'b0; MM = 1'($urandom_range(0, 1)); PC = 6'($urandom);
      MB = mb; FS = fs; SA = sa; SB = sb; DR = dr; RW = rw;
      check({tag, "_in_ready"}, in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      check({tag, "_dataout"}, DataOut, exp);
      check({tag, "_z"}, Z, (exp == 16'h0000));
      check({tag, "_wb_valid"}, wb_valid, 1'b1);
      if (rw) regs[dr] = exp;
      last_do = exp;
      last_z  = (exp == 16'h0000);
   endtask

   task automatic issue_load(input logic mm, input logic [5:0] pc, input logic [3:0] sa,
                             input logic [3:0] dr, input logic rw, input int delay,
                             input logic [15:0] data, input string tag);
      logic [5:0] addr;
      int reqcnt;
      addr = mm ? pc : regs[sa][5:0];
      in_valid = 1'b1;
      MD = 1'b1; MM = mm; PC = pc; SA = sa; DR = dr; RW = rw;
      MB = 1'($urandom_range(0, 1)); FS = 4'($urandom); SB = 4'($urandom);
      tick();
      check({tag, "_addrout"}, AddrOut, addr);
      check({tag, "_in_ready_wait"}, in_ready, 1'b0);
      check({tag, "_wb_valid_start"}, wb_valid, 1'b0);
      // Ops offered while stalled must be ignored.
      MD = 1'b0; FS = 4'b1100; MB = 1'b1; RW = 1'b1; DR = 4'($urandom);
      reqcnt = 0;
      for (int k = 1; k <= delay; k++) begin
         if (mem_req) reqcnt++;
         if (k == delay) begin
            mem_ack = 1'b1;
            DataIn  = data;
         end else begin
            mem_ack = 1'b0;
            DataIn  = 16'($urandom);
         end
         tick();
         if (k < delay) check({tag, "_wb_valid_wait"}, wb_valid, 1'b0);
      end
      mem_ack  = 1'b0;
      in_valid = 1'b0;
      check({tag, "_req_cycles"}, reqcnt, delay);
      check({tag, "_dataout"}, DataOut, data);
      check({tag, "_z"}, Z, (data == 16'h0000));
      check({tag, "_wb_valid"}, wb_valid, 1'b1);
      check({tag, "_mem_req_drop"}, mem_req, 1'b0);
      check({tag, "_in_ready"}, in_ready, 1'b1);
      if (rw) regs[dr] = data;
      last_do   = data;
      last_z    = (data == 16'h0000);
      last_addr = addr;
   endtask

   task automatic idle(input string tag);
      in_valid = 1'b0;
      tick();
      check({tag, "_wb_valid"}, wb_valid, 1'b0);
      check({tag, "_hold_do"}, DataOut, last_do);
      check({tag, "_hold_z"}, Z, last_z);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; MB = 0; MM = 0; MD = 0; RW = 0;
      DR = 0; SA = 0; SB = 0; FS = 0; PC = 0; DataIn = 0; mem_ack = 1'b0;
      model_clear();
      tick();
      do_reset("reset");

      // Immediate add, then dependent increment through forwarding.
      issue_alu(4'b0010, 1'b1, 4'h0, 4'h5, 4'h1, 1'b1, "imm_add");
      issue_alu(4'b0001, 1'b0, 4'h1, 4'h0, 4'h2, 1'b1, "fwd_inc");
      issue_alu(4'b0000, 1'b0, 4'h2, 4'h0, 4'h0, 1'b0, "read_r2");
      check("r2_is_6", last_do, 16'h0006);

      // Subtract to zero: single wb_valid pulse.
      issue_alu(4'b1100, 1'b1, 4'h0, 4'h7, 4'h3, 1'b1, "load_r3");
      issue_alu(4'b0101, 1'b0, 4'h3, 4'h3, 4'h4, 1'b1, "sub_zero");
      check("sub_zero_flag", Z, 1'b1);
      idle("after_sub");

      // Load with 3-cycle ack delay, then read it back.
      issue_load(1'b1, 6'h2A, 4'h0, 4'h5, 1'b1, 3, 16'hBEEF, "load_pc");
      check("load_pc_addr", AddrOut, 6'h2A);
      issue_alu(4'b0000, 1'b0, 4'h5, 4'h0, 4'h0, 1'b0, "read_r5");

      // Unused opcode and RW=0 op.
      issue_alu(4'b0111, 1'b0, 4'h5, 4'h3, 4'h3, 1'b0, "fs_0111");
      check("fs_0111_z", Z, 1'b1);
      issue_alu(4'b0000, 1'b0, 4'h3, 4'h0, 4'h0, 1'b0, "r3_unchanged");
      check("r3_still_7", DataOut, 16'h0007);

      // Reset while waiting for memory abandons the load.
      in_valid = 1'b1; MD = 1'b1; MM = 1'b1; PC = 6'h11; DR = 4'h6; RW = 1'b1;
      tick();
      check("rmw_mem_req", mem_req, 1'b1);
      in_valid = 1'b0;
      tick();
      do_reset("rmw_reset");
      mem_ack = 1'b1; DataIn = 16'h1234;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("rmw_late_ack_wb", wb_valid, 1'b0);
         check("rmw_late_ack_req", mem_req, 1'b0);
         check("rmw_late_ack_do", DataOut, 16'h0000);
      end
      mem_ack = 1'b0;
      issue_alu(4'b0000, 1'b0, 4'h6, 4'h0, 4'h0, 1'b0, "rmw_r6_zero");

      // Random mix of ops, loads, idles and occasional reset.
      for (int it = 0; it < 400; it++) begin
         int r;
         r = int'($urandom_range(0, 11));
         if (it % 150 == 75) do_reset("rnd_reset");
         else if (r <= 8)
            issue_alu(4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                      4'($urandom), 1'($urandom_range(0, 3) != 0), "rnd_alu");
         else if (r <= 10)
            issue_load(1'($urandom_range(0, 1)), 6'($urandom), 4'($urandom), 4'($urandom),
                       1'($urandom_range(0, 3) != 0), int'($urandom_range(1, 4)),
                       16'($urandom_range(0, 3) == 0 ? 0 : $urandom), "rnd_load");
         else
            idle("rnd_idle");
      end

      // Final sweep: every register matches the model.
      for (int i = 0; i < 16; i++)
         issue_alu(4'b0000, 1'b0, 4'(i), 4'h0, 4'h0, 1'b0, "sweep");
      check("sweep_addr_hold", AddrOut, last_addr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/datapath_pipe.md
DATAPATH_PIPE -- requirements
Module: datapath_pipe

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 Parameter RAW, default 4: register-address width; the register file holds 2**RAW words.
REQ-003 Parameter AW, default 6: memory address width; legal only if WIDTH >= 2*RAW and WIDTH >= AW.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk_main  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid / in_ready  in/out  1/1  operation handshake; an operation is accepted on an edge where both are high.
REQ-008 MB, MM, MD, RW  in  1 each  B-operand select (immediate), address select (PC), load select, register write enable.
REQ-009 DR, SA, SB  in  RAW each  destination, A-source and B-source register addresses.
REQ-010 FS  in  4  ALU function select.
REQ-011 PC  in  AW  program counter for address select.
REQ-012 DataIn  in  WIDTH  memory read data, valid while mem_ack is high.
REQ-013 mem_req / mem_ack  out/in  1/1  load handshake.
REQ-014 AddrOut  out  AW  registered memory address.
REQ-015 DataOut  out  WIDTH  write-back data register.
REQ-016 Z  out  1  registered zero flag of the last write-back value.
REQ-017 wb_valid  out  1  high for one cycle when the write-back register holds a new result.

Function
REQ-018 FSM states: RUN and MEM_WAIT; in_ready is high only in RUN.
REQ-019 B operand is regfile[SB] when MB=0, and {SA,SB} zero-extended to WIDTH when MB=1.
REQ-020 ALU ops (results truncated to WIDTH; carries discarded):
- 0000 A; 0001 A+1; 0010 A+B; 0101 A-B; 0110 A-1
- 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A
- 1100 B; 1101 B>>1 (logical); 1110 B<<1
- every other code gives 0.
REQ-021 Accepted op with MD=0: on the accept edge the ALU result loads the write-back register (DataOut), Z is set to (result==0), wb_valid goes high, and the destination and RW are latched.
REQ-022 Accepted op with MD=1: on the accept edge AddrOut loads PC if MM=1, else A[AW-1:0]; mem_req goes high; the FSM enters MEM_WAIT.
REQ-023 In MEM_WAIT: mem_ack is sampled only while mem_req is high; on an edge with mem_ack high, DataIn loads the write-back register, Z is updated, wb_valid pulses, mem_req drops, and the FSM returns to RUN.
REQ-024 Register-file write occurs on the edge after the write-back register loads, only if the latched RW=1, to the latched DR.
REQ-025 Forwarding: an operand read whose address equals the pending write-back destination (latched RW=1, write not yet done) uses the write-back register instead of the register-file value.
REQ-026 Back-to-back dependent ALU ops (one per cycle) produce the same results as if they were executed serially.
REQ-027 wb_valid is low in any cycle without a new write-back; DataOut, Z and AddrOut hold their values otherwise.
REQ-028 in_valid while in_ready is low is ignored; the other inputs are don't-care then.

Reset
REQ-029 Reset forces: FSM to RUN; all registers, DataOut, AddrOut, Z, wb_valid and mem_req to 0; no pending write-back.
REQ-030 Reset during MEM_WAIT abandons the load: mem_req is 0 the cycle after reset and a late mem_ack is ignored.
REQ-031 An op presented on a reset edge is not accepted.

Structure
REQ-032 A shared package holds the FS opcode constants and the FSM state enum.
REQ-033 One sub-module: regfile_param (2**RAW x WIDTH, two combinational read ports, one synchronous write port, synchronous reset).

Verification
REQ-034 Immediate add then forward: R1=0 after reset; op FS=0010, MB=1, SA=0, SB=5, DR=1, RW=1, then next cycle FS=0001, SA=1, DR=2 -> DataOut 0x0005 then 0x0006; R2 ends at 6.
REQ-035 Subtract to zero: R3=7 loaded; FS=0101 with SA=3, SB=3 -> DataOut 0, Z=1, wb_valid pulses once.
REQ-036 Load with 3-cycle ack delay: MD=1, MM=1, PC=0x2A, DataIn=0xBEEF -> AddrOut=0x2A, mem_req high for 3 cycles, in_ready low, then DR=0xBEEF.
REQ-037 Reset in MEM_WAIT -> mem_req=0, in_ready=1, no register write, and a following ack is ignored.
REQ-038 Unused FS=0111 -> DataOut 0, Z=1; RW=0 op -> register file unchanged.
